// File: rtl/regfile_arb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_arb_pkg
// Shared types and default widths for the register-file write arbiter.
//   state_e : arbiter FSM state (INIT = clearing x1..x31, RUN = arbitrating)
//   src_e   : writeback source identity, used as the round-robin pointer
//   DATA_W  : default register data width
//   ADDR_W  : default register address width (2**ADDR_W registers)
// ---------------------------------------------------------------------------
package regfile_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
// Bundles the two writeback request channels and the register-file write
// port driven by the arbiter.
//   alu_valid/alu_ready/alu_rd/alu_wd : ALU writeback channel
//   ld_valid/ld_ready/ld_rd/ld_wd     : load writeback channel
//   init_done                         : clear sequence finished
//   we3/a3/wd3                        : register-file write port
// Modports:
//   master : the request side (execute/memory stages, or a bench)
//   slave  : the arbiter
//
// Handshake: a transfer happens in a cycle where valid and ready are both
// high. A source raises valid with stable rd/wd and holds all three until
// that transfer; valid never depends on ready. ready may depend
// combinationally on both valids in the same cycle.
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = regfile_arb_pkg::DATA_W,
    parameter int ADDR_W = regfile_arb_pkg::ADDR_W
);

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_wd;

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_wd;

    logic              init_done;
    logic              we3;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd3;

    modport master (
        output alu_valid, alu_rd, alu_wd,
        output ld_valid, ld_rd, ld_wd,
        input  alu_ready, ld_ready,
        input  init_done, we3, a3, wd3
    );

    modport slave (
        input  alu_valid, alu_rd, alu_wd,
        input  ld_valid, ld_rd, ld_wd,
        output alu_ready, ld_ready,
        output init_done, we3, a3, wd3
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. Bit 0 is the ALU, bit 1 the load path.
// When both request, the one not granted last wins; a lone requester always
// wins. The last-grant pointer moves only when advance_i is high and a grant
// is issued.
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset (pointer = SRC_LD, so the ALU
//               wins the first contended cycle)
//   req_i     : request vector {ld, alu}
//   advance_i : commit this cycle's grant into the pointer
//   grant_o   : one-hot grant vector {ld, alu}
// ---------------------------------------------------------------------------
module rr_arb2
    import regfile_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    src_e last_q;
    src_e last_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= SRC_LD;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_q == SRC_LD) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (advance_i && grant_o[0]) begin
            last_d = SRC_ALU;
        end else if (advance_i && grant_o[1]) begin
            last_d = SRC_LD;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Sole owner of the register file write port. After reset it writes zero to
// x1..x(2**ADDR_W-1), one register per cycle (INIT), then shares the port
// round-robin between the ALU and load writeback sources (RUN).
//   clk         : rising-edge clock
//   reset       : synchronous active-high reset
//   bus         : request channels + write port (slave side)
//   dbg_state_o : current FSM state, for observation only
// Parameters:
//   DATA_W, ADDR_W  : data / address widths (must match the bus instance)
//   CLEAR_ON_RESET  : 1 = run the clear sequence after reset, 0 = go to RUN
// All bus outputs are combinational from state and request inputs; the
// register file captures we3/a3/wd3 at the next rising edge.
// ---------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W         = regfile_arb_pkg::DATA_W,
    parameter int ADDR_W         = regfile_arb_pkg::ADDR_W,
    parameter bit CLEAR_ON_RESET = 1'b1
)(
    input  logic                     clk,
    input  logic                     reset,
    regfile_write_arbiter_if.slave   bus,
    output state_e                   dbg_state_o
);

    localparam logic [ADDR_W-1:0] LAST_REG = '1;
    localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    logic              run_active;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_wd;

    // Outputs are forced quiet during reset even though state_q still holds
    // the pre-reset value in that cycle.
    assign run_active  = (state_q == RUN) && !reset;
    assign req         = run_active ? {bus.ld_valid, bus.alu_valid} : 2'b00;
    assign dbg_state_o = state_q;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req),
        .advance_i (run_active),
        .grant_o   (grant)
    );

    // State register (FSM state + clear counter).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? INIT : RUN;
            cnt_q   <= FIRST_REG;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. The counter starts at 1 so x0 is never addressed;
    // the last register write happens in the same cycle the FSM leaves INIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_REG) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Source mux for the granted request.
    always_comb begin
        sel_rd = '0;
        sel_wd = '0;
        if (grant[0]) begin
            sel_rd = bus.alu_rd;
            sel_wd = bus.alu_wd;
        end else if (grant[1]) begin
            sel_rd = bus.ld_rd;
            sel_wd = bus.ld_wd;
        end
    end

    // Output logic. A grant to x0 still acks the source but suppresses we3.
    always_comb begin
        bus.we3       = 1'b0;
        bus.a3        = '0;
        bus.wd3       = '0;
        bus.alu_ready = 1'b0;
        bus.ld_ready  = 1'b0;
        bus.init_done = 1'b0;
        if (!reset) begin
            case (state_q)
                INIT: begin
                    bus.we3 = 1'b1;
                    bus.a3  = cnt_q;
                end
                RUN: begin
                    bus.init_done = 1'b1;
                    bus.alu_ready = grant[0];
                    bus.ld_ready  = grant[1];
                    bus.a3        = sel_rd;
                    bus.wd3       = sel_wd;
                    bus.we3       = (|grant) && (sel_rd != '0);
                end
                default: begin
                    bus.we3 = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Owns the single write port (we3/a3/wd3) of the three-ported 32×32 register file and shares it between two writeback sources: the ALU result path and the load-data path. After reset it first sequences a clear of x1..x31 to zero, then arbitrates round-robin between the two sources using valid/ready handshakes. It sits between the execute/memory stages and the register file and is the only block that drives the write port.

## Interface

- DATA_W, 32, register data width
- ADDR_W, 5, register address width; the register file holds 2**ADDR_W entries
- CLEAR_ON_RESET, 1, 1 = run the post-reset clear sequence; 0 = skip it

- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd  in  ADDR_W  ALU destination register
- alu_wd  in  DATA_W  ALU write data
- ld_valid  in  1  load writeback request
- ld_ready  out  1  load request accepted this cycle
- ld_rd  in  ADDR_W  load destination register
- ld_wd  in  DATA_W  load write data
- init_done  out  1  high once the clear sequence has completed; stays high until reset
- we3  out  1  register file write enable
- a3  out  ADDR_W  register file write address
- wd3  out  DATA_W  register file write data

## Operation

- FSM states: INIT and RUN. The state register, the clear counter and the round-robin pointer are the only state.
- Reset:
  - While reset is high, state goes to INIT if CLEAR_ON_RESET=1, otherwise to RUN.
  - Clear counter resets to 1. Round-robin pointer resets so the ALU has priority (last grant = LD).
  - While reset is high: we3=0, alu_ready=0, ld_ready=0, init_done=0.
- INIT:
  - Outputs: we3=1, a3=counter, wd3=0, both ready signals 0.
  - The counter increments every cycle.
  - When counter = 2**ADDR_W−1, the write to that register occurs and the next state is RUN.
  - x0 is never written.
- RUN:
  - init_done=1.
  - Exactly one source is granted per cycle:
    - Only one source valid: that source is granted.
    - Both valid: the source not granted last is granted.
  - The pointer updates only on a grant.
  - Grant behaviour: ready=1 for the granted source only, a3=rd, wd3=wd.
  - we3=1 only if the granted rd ≠ 0. A request to x0 still completes its handshake and still consumes the grant, but performs no write.
  - No request: we3=0, a3=0, wd3=0.
- Handshake rules:
  - A transfer occurs when valid && ready are both high in the same cycle.
  - Sources hold valid, rd and wd stable until the transfer.
  - ready may depend combinationally on both valids; valid must not depend on ready.
- Reset mid-operation (INIT or RUN): all state is discarded and the clear sequence restarts from x1. A pending un-acked request is neither written nor acked.

## Timing

- we3, a3, wd3 and both ready signals are combinational from the current state and the request inputs. The register file captures the write at the next rising edge, so writes have 1-cycle latency.
- With CLEAR_ON_RESET=1 and reset deasserted before edge E:
  - Cycles E..E+30 write x1..x31.
  - init_done rises in cycle E+31.
  - The first grant is possible in cycle E+31.
- With CLEAR_ON_RESET=0: init_done=1 and grants are possible in the first cycle after reset deasserts.
- Throughput is one write per cycle. Under continuous contention the grants strictly alternate ALU, LD, ALU, …, and each source waits at most 1 cycle.
- Requests raised during INIT are held off (ready=0) and granted from the first RUN cycle; the ALU wins if both are pending.

## Structure

- Package regfile_arb_pkg holds:
  - state enum: INIT, RUN
  - source enum: SRC_ALU, SRC_LD
  - default width constants: DATA_W, ADDR_W
- Sub-module rr_arb2 is a 2-requester round-robin arbiter:
  - inputs: req[1:0], advance
  - outputs: one-hot grant[1:0]
  - internal: last-grant flop, synchronous active-high reset
- The top level contains the FSM, the clear counter and the write-port mux.

## Test plan

- Reset, then idle with CLEAR_ON_RESET=1 → we3=1 for exactly 31 cycles with a3=1..31 and wd3=0; init_done=1 from cycle 31 after reset release; reading x5 afterwards returns 0.
- ALU only: alu_valid=1, alu_rd=3, alu_wd=0xDEADBEEF → alu_ready=1 in the same cycle, we3=1, a3=3; rd1 of x3 = 0xDEADBEEF on the next cycle.
- Both sources held valid for 4 cycles (ALU x1=0x11, LD x2=0x22, rd/wd held) → grant order ALU, LD, ALU, LD; never both ready in one cycle.
- LD request with ld_rd=0 and ld_wd=0xFFFFFFFF → ld_ready=1, we3=0; x0 reads 0.
- Both sources valid during cycle 10 of INIT → both readies stay 0 until RUN; the ALU is granted in the first RUN cycle and LD in the next.
- Reset asserted in RUN while LD is waiting → no ack and no write; the clear restarts at x1 one cycle after reset release; init_done stays low for 31 cycles.
